// File: rtl/audio_serial_rx.sv
// I2S / left-justified serial audio receiver, oversampled by clk.
// Rebuilds 16-bit left/right sample pairs and commits them per frame.
module audio_serial_rx #(
  parameter int WIDTH       = 16,
  parameter int DATA_DELAY  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             audio_bck,
  input  logic             audio_ws,
  input  logic             audio_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] audio_out_left,
  output logic [WIDTH-1:0] audio_out_right,
  output logic             sample_valid,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   bck_d;
  logic                   bck_rise;
  logic                   ws;
  logic                   data;
  logic                   ws_prev;
  logic                   ws_edge;
  logic [WIDTH-1:0]       shreg;
  logic [WIDTH-1:0]       pending;
  logic [WIDTH-1:0]       shreg_in;
  logic [CW-1:0]          cnt;
  logic                   lpv;
  logic                   commit_q;

  logic do_shift;
  logic cnt_clr;
  logic load_left;
  logic commit;
  logic err_set;
  logic lpv_clr;

  assign ws       = ws_sync[SYNC_STAGES-1];
  assign data     = data_sync[SYNC_STAGES-1];
  assign bck_rise = bck_sync[SYNC_STAGES-1] & ~bck_d;
  assign ws_edge  = ws != ws_prev;
  assign shreg_in = {shreg[WIDTH-2:0], data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bck_sync  <= '0;
      ws_sync   <= '0;
      data_sync <= '0;
      bck_d     <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], audio_bck};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], audio_ws};
      data_sync <= {data_sync[SYNC_STAGES-2:0], audio_data};
      bck_d     <= bck_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The bit at the ws edge is either the MSB (left-justified)
  // or the I2S delay slot, in which case SKIP takes the MSB.
  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    cnt_clr   = 1'b0;
    load_left = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    lpv_clr   = 1'b0;
    if (bck_rise) begin
      if (state == IDLE) begin
        if (ws_edge && !ws) begin
          cnt_clr = 1'b1;
          lpv_clr = 1'b1;
          if (DATA_DELAY == 0) begin
            state_nxt = SHIFT;
            do_shift  = 1'b1;
          end else begin
            state_nxt = SKIP;
          end
        end
      end else if (ws_edge) begin
        if (state == SHIFT) begin
          err_set = 1'b1;
          if (!ws_prev) lpv_clr = 1'b1;
        end
        if (!ws) lpv_clr = 1'b1;
        cnt_clr = 1'b1;
        if (DATA_DELAY == 0) begin
          state_nxt = SHIFT;
          do_shift  = 1'b1;
        end else begin
          state_nxt = SKIP;
        end
      end else begin
        unique case (state)
          SKIP: begin
            cnt_clr   = 1'b1;
            do_shift  = 1'b1;
            state_nxt = SHIFT;
          end
          SHIFT: begin
            do_shift = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state_nxt = HOLD;
              if (ws) commit    = lpv;
              else    load_left = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_prev  <= 1'b0;
      shreg    <= '0;
      pending  <= '0;
      cnt      <= '0;
      lpv      <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      if (bck_rise) ws_prev <= ws;
      if (do_shift) shreg <= shreg_in;
      if (load_left) pending <= shreg_in;
      if (cnt_clr)       cnt <= do_shift ? CW'(1) : '0;
      else if (do_shift) cnt <= cnt + 1'b1;
      if (load_left)    lpv <= 1'b1;
      else if (lpv_clr) lpv <= 1'b0;
      commit_q <= commit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out_left  <= '0;
      audio_out_right <= '0;
      sample_valid    <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      sample_valid <= commit_q;
      if (commit_q) begin
        audio_out_left  <= pending;
        audio_out_right <= shreg;
      end
      if (err_set)      frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_serial_rx.sv
// Scoreboard bench for audio_serial_rx: I2S and left-justified
// instances, directed frames, short word, and mid-word reset.
module tb_audio_serial_rx;
  logic        clk;
  logic        reset;
  logic        bck0, bck1;
  logic        ws, data;
  logic        err_clr;
  logic [15:0] l0, r0, l1, r1;
  logic        sv0, sv1, fe0, fe1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  time         lsb_t[2];

  audio_serial_rx #(.WIDTH(16), .DATA_DELAY(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .audio_bck(bck0), .audio_ws(ws),
    .audio_data(data), .err_clr(err_clr),
    .audio_out_left(l0), .audio_out_right(r0),
    .sample_valid(sv0), .frame_err(fe0)
  );

  audio_serial_rx #(.WIDTH(16), .DATA_DELAY(0), .SYNC_STAGES(2)) dut_lj (
    .clk(clk), .reset(reset), .audio_bck(bck1), .audio_ws(ws),
    .audio_data(data), .err_clr(err_clr),
    .audio_out_left(l1), .audio_out_right(r1),
    .sample_valid(sv1), .frame_err(fe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int m, input logic [15:0] l,
                     input logic [15:0] r);
    logic [31:0] e;
    time         dt;
    checks++;
    if (m == 0 ? q0.size() == 0 : q1.size() == 0) begin
      errors++;
      $display("FAIL unexpected_valid%0d: got %h/%h expected none",
               m, l, r);
    end else begin
      e = (m == 0) ? q0.pop_front() : q1.pop_front();
      if ({l, r} !== e) begin
        errors++;
        $display("FAIL sample%0d: got %h expected %h", m, {l, r}, e);
      end
      checks++;
      dt = $time - lsb_t[m];
      if (dt < 30 || dt > 50) begin
        errors++;
        $display("FAIL latency%0d: got %0t expected 40 +-10", m, dt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sv0) mon(0, l0, r0);
    if (sv1) mon(1, l1, r1);
  end

  task automatic send_bit(input int m, input logic w, input logic d,
                          input logic rec);
    ws   = w;
    data = d;
    repeat (4) @(negedge clk);
    if (m == 0) bck0 = 1'b1;
    else        bck1 = 1'b1;
    if (rec) lsb_t[m] = $time;
    repeat (4) @(negedge clk);
    bck0 = 1'b0;
    bck1 = 1'b0;
  endtask

  task automatic send_word(input int m, input logic w,
                           input logic [15:0] s, input int nbits);
    int   pos;
    logic b;
    for (int i = 0; i < nbits; i++) begin
      pos = (m == 0) ? i - 1 : i;
      b = (pos >= 0 && pos < 16) ? s[15 - pos] : 1'b0;
      send_bit(m, w, b, w && pos == 15);
    end
  endtask

  task automatic send_frame(input int m, input logic [15:0] l,
                            input logic [15:0] r, input logic good);
    if (good) begin
      if (m == 0) q0.push_back({l, r});
      else        q1.push_back({l, r});
    end
    send_word(m, 1'b0, l, 32);
    send_word(m, 1'b1, r, 32);
  endtask

  initial begin
    reset   = 1'b1;
    bck0    = 1'b0;
    bck1    = 1'b0;
    ws      = 1'b1;
    data    = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_left", {16'h0, l0}, 32'h0);
    chk("reset_right", {16'h0, r0}, 32'h0);
    chk("reset_valid_err", {30'h0, sv0, fe0}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    send_word(0, 1'b1, 16'h0, 4);
    send_frame(0, 16'h1234, 16'hABCD, 1'b1);
    chk("nominal_left", {16'h0, l0}, 32'h1234);
    chk("nominal_right", {16'h0, r0}, 32'hABCD);
    send_frame(0, 16'h5A5A, 16'h0F0F, 1'b1);

    for (int f = 0; f < 10; f++)
      send_frame(0, 16'h7FFF, 16'h8000, 1'b1);
    chk("loop_err", {31'h0, fe0}, 32'h0);

    send_word(0, 1'b0, 16'hFFFF, 11);
    send_word(0, 1'b1, 16'h1111, 32);
    chk("short_err", {31'h0, fe0}, 32'h1);
    chk("short_hold", {l0, r0}, 32'h7FFF8000);
    send_frame(0, 16'hCAFE, 16'hBEEF, 1'b1);
    chk("after_short", {l0, r0}, 32'hCAFEBEEF);
    chk("err_sticky", {31'h0, fe0}, 32'h1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {31'h0, fe0}, 32'h0);

    send_word(0, 1'b0, 16'h1357, 32);
    send_word(0, 1'b1, 16'hFFFF, 9);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_out", {l0, r0}, 32'h0);
    chk("midreset_valid", {31'h0, sv0}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_word(0, 1'b1, 16'hFFFF, 23);
    chk("midreset_hold", {l0, r0}, 32'h0);
    send_frame(0, 16'h2468, 16'h1357, 1'b1);
    chk("resume", {l0, r0}, 32'h24681357);

    send_word(1, 1'b1, 16'h0, 4);
    send_frame(1, 16'h8001, 16'h0001, 1'b1);
    chk("lj_out", {l1, r1}, 32'h80010001);
    send_frame(1, 16'h8000, 16'hFFFF, 1'b1);
    chk("lj_err", {31'h0, fe1}, 32'h0);

    repeat (20) @(negedge clk);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
